video_timing_gen: RTL and testbench
===================================

# video_timing_gen

Parametrised raster timing generator: the successor to the fixed-count per-game video block, used for any board in this codebase. It produces horizontal and vertical counters, blanking and active-low sync, CPU interrupt strobes, and flip-adjusted counters for the tile and sprite engines. New over the fixed generator:
- pixel clock enable
- parametrised geometry
- runtime sync-position adjust, applied per frame
- latched IRQ with acknowledge
- frame counter

## Interface
Parameters:
- CW, 9: counter width, for hcount/vcount and all positions.
- H_TOTAL, 401: pixels per line; hcount runs 0..H_TOTAL-1.
- HB_END, 1: hcount at which hb falls.
- HB_START, 241: hcount at which hb rises.
- HS_START, 289: hcount at which hs falls.
- HS_END, 321: hcount at which hs rises.
- V_TOTAL, 260: lines per frame; vcount runs 0..V_TOTAL-1.
- VB_END, 0: line at which vb falls.
- VB_START, 240: line at which vb rises.
- VS_START, 243: line at which vs falls.
- VS_END, 253: line at which vs rises.
- NMI_LINE, 239: line of the NMI pulse.
- IRQ_SHIFT, 3: IRQ fires on lines where vcount[IRQ_SHIFT-1:0] is all ones. 0 disables IRQ.
- FLIP_XMAX, 255 / FLIP_YMAX, 255: mirror bases for the flipped counters.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- ce_pix, in, 1: pixel enable. All state advances only on cycles with ce_pix=1.
- flip, in, 1: screen flip.
- h_adj, in, 4: signed sync shift in pixels, -8..+7.
- v_adj, in, 3: signed sync shift in lines, -4..+3.
- irq_ack, in, 1: clears irq.
- hcount, out, CW: horizontal counter.
- vcount, out, CW: vertical counter.
- hcount_f, out, CW: hcount, or FLIP_XMAX-hcount when flip=1. Registered.
- vcount_f, out, CW: same scheme for vcount.
- hb / vb, out, 1: blanking, active high.
- hs / vs, out, 1: sync, active low.
- nmi, out, 1: one-ce_pix pulse.
- irq, out, 1: level, held until irq_ack.
- frame, out, 8: frame counter, wraps at 255.

## Operation
- **Counters.** On ce_pix, hcount increments. At H_TOTAL-1, hcount wraps to 0 and vcount increments. At vcount=V_TOTAL-1 together with the hcount wrap, vcount wraps to 0 and frame increments, modulo 256.
- **Horizontal edges.** hb, hs set/clear when hcount equals their parameter position, evaluated on the ce_pix cycle holding that count.
- **Vertical edges.** vb, vs are evaluated only on the line-wrap cycle, against the pre-increment vcount.
- **Effective sync positions.** hs uses HS_START+h_adj_r and HS_END+h_adj_r; vs uses VS_START+v_adj_r and VS_END+v_adj_r.
  - Sums use CW-bit modulo arithmetic, wrapping modulo H_TOTAL/V_TOTAL.
  - h_adj_r and v_adj_r are captured from h_adj/v_adj only on the frame-wrap cycle, so sync never tears mid-frame.
  - Blanking is never adjusted.
- **NMI.** nmi=1 for exactly one ce_pix cycle, when vcount=NMI_LINE and hcount=0.
- **IRQ.** irq sets when hcount=0 and vcount's low IRQ_SHIFT bits are all ones. irq clears on irq_ack.
  - Set and ack in the same cycle: set wins.
  - irq_ack with irq=0: no effect.
- **irq_ack has no ce gating.** irq_ack is sampled every clk, independent of ce_pix.
- **Flipped counters.** hcount_f/vcount_f follow flip combinationally into a register, so they update on the next clk even without ce_pix. A flip change mid-frame takes effect immediately; no frame synchronisation.
- **Stall.** ce_pix=0 holds all state except irq (ack path) and hcount_f/vcount_f.

## Timing
- **Reset values** (reset=1 for any clk, regardless of ce_pix):
  - hcount=0, vcount=0, frame=0
  - hb=1, vb=1, hs=1, vs=1
  - nmi=0, irq=0
  - h_adj_r=0, v_adj_r=0
  - hcount_f, vcount_f = reset counters mirrored per current flip
- **Latency.**
  - Outputs are registered; an edge at count N is visible on the clk following the ce_pix cycle where the counter equals N.
  - hcount_f/vcount_f lag hcount/vcount by one clk.
- **Reset mid-line.** Counters restart at 0. The first line after reset is a full H_TOTAL pixels. vb rises again at line VB_START; until then it stays 1 from reset unless VB_END=0 triggers at the first wrap.
- **Equal positions.** HS_START+h_adj_r=HS_END+h_adj_r: the clear is applied last, so hs stays high.
- **Elaboration check.** V_TOTAL ≤ 2^CW and H_TOTAL ≤ 2^CW.

## Structure
- Package video_timing_pkg holds:
  - typedef cnt_t (CW bits)
  - function wrap_add(pos, adj, total)
  - default-geometry constants for the existing boards, e.g. VBALL_H_TOTAL=401, VBALL_V_TOTAL=260
- One sub-module: video_sync_window, one per axis. It takes a counter, a step strobe, start/end positions, an adj value and a latch strobe, and outputs the sync level.
- Counters, interrupts and flip stay in the top module.

## Test plan
- **Default geometry, ce_pix=1 always.** hb falls at hcount=1 and rises at 241. hs is low for hcount 289..320. One line = 401 clk. One frame = 260 lines = 104260 clk.
- **NMI/IRQ cadence.** nmi pulses once per frame, at line 239, hcount 0. irq sets at lines 7, 15, …, 255. Ack 10 clk after set clears it. Ack on the exact set cycle leaves irq=1.
- **ce_pix divide-by-4.** All periods scale by 4. With flip=1, hcount_f=255-hcount one clk after each count change.
- **h_adj=-3 written mid-frame.** The hs window stays 289..320 until the frame wrap, then moves to 286..317. v_adj=+3 moves vs to lines 246..255 on the next frame.
- **Reset asserted at hcount=150, vcount=100 with irq=1.** Next clk shows hcount=0, vcount=0, irq=0, hb=vb=hs=vs=1, frame=0.
- **Frame counter.** After 256 frames, frame wraps 255→0 on the wrap cycle.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types, board geometry defaults and position arithmetic for the
// raster timing generator.
package video_timing_pkg;

    localparam int CNT_W = 9;

    typedef logic [CNT_W-1:0] cnt_t;

    // Geometry of the volleyball board, the default for the generator.
    localparam int VBALL_H_TOTAL  = 401;
    localparam int VBALL_HB_END   = 1;
    localparam int VBALL_HB_START = 241;
    localparam int VBALL_HS_START = 289;
    localparam int VBALL_HS_END   = 321;
    localparam int VBALL_V_TOTAL  = 260;
    localparam int VBALL_VB_END   = 0;
    localparam int VBALL_VB_START = 240;
    localparam int VBALL_VS_START = 243;
    localparam int VBALL_VS_END   = 253;
    localparam int VBALL_NMI_LINE = 239;

    // Adds a signed shift to a position and folds the result back into 0..total-1.
    function automatic int wrap_add(input int pos, input int adj, input int total);
        int sum;
        sum = pos + adj;
        if (sum < 0) begin
            sum = sum + total;
        end else if (sum >= total) begin
            sum = sum - total;
        end
        return sum;
    endfunction

endpackage

// File: rtl/video_timing_gen_sync.sv
// One axis of sync generation: a level that falls at the shifted start
// position and rises at the shifted end position. The shift is latched only
// on the latch strobe so a frame never sees two different sync positions.
module video_sync_window
    import video_timing_pkg::*;
#(
    parameter int CW    = 9,
    parameter int TOTAL = 401,
    parameter int START = 289,
    parameter int STOP  = 321,
    parameter int AW    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_i,
    input  logic                 latch_i,
    input  logic [CW-1:0]        cnt_i,
    input  logic signed [AW-1:0] adj_i,
    output logic                 sync_o
);

    logic signed [AW-1:0] adj_q;
    logic                 sync_q;
    logic                 sync_d;
    logic [CW-1:0]        startPos;
    logic [CW-1:0]        stopPos;

    assign startPos = CW'(wrap_add(START, int'(adj_q), TOTAL));
    assign stopPos  = CW'(wrap_add(STOP, int'(adj_q), TOTAL));

    // Next sync level; the release is applied after the assert so equal positions leave sync high.
    always_comb begin
        sync_d = sync_q;
        if (step_i) begin
            if (cnt_i == startPos) begin
                sync_d = 1'b0;
            end
            if (cnt_i == stopPos) begin
                sync_d = 1'b1;
            end
        end
    end

    // Sync level and the per-frame copy of the position shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            adj_q  <= '0;
            sync_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            if (latch_i) begin
                adj_q <= adj_i;
            end
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: counters, blanking, sync, NMI/IRQ
// strobes, frame counter and flip-mirrored counters for the video engines.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CW        = 9,
    parameter int H_TOTAL   = VBALL_H_TOTAL,
    parameter int HB_END    = VBALL_HB_END,
    parameter int HB_START  = VBALL_HB_START,
    parameter int HS_START  = VBALL_HS_START,
    parameter int HS_END    = VBALL_HS_END,
    parameter int V_TOTAL   = VBALL_V_TOTAL,
    parameter int VB_END    = VBALL_VB_END,
    parameter int VB_START  = VBALL_VB_START,
    parameter int VS_START  = VBALL_VS_START,
    parameter int VS_END    = VBALL_VS_END,
    parameter int NMI_LINE  = VBALL_NMI_LINE,
    parameter int IRQ_SHIFT = 3,
    parameter int FLIP_XMAX = 255,
    parameter int FLIP_YMAX = 255
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce_pix,
    input  logic          flip,
    input  logic [3:0]    h_adj,
    input  logic [2:0]    v_adj,
    input  logic          irq_ack,
    output logic [CW-1:0] hcount,
    output logic [CW-1:0] vcount,
    output logic [CW-1:0] hcount_f,
    output logic [CW-1:0] vcount_f,
    output logic          hb,
    output logic          vb,
    output logic          hs,
    output logic          vs,
    output logic          nmi,
    output logic          irq,
    output logic [7:0]    frame
);

    localparam logic [CW-1:0] ONE_C      = CW'(1);
    localparam logic [CW-1:0] H_LAST_C   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST_C   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HB_END_C   = CW'(HB_END);
    localparam logic [CW-1:0] HB_START_C = CW'(HB_START);
    localparam logic [CW-1:0] VB_END_C   = CW'(VB_END);
    localparam logic [CW-1:0] VB_START_C = CW'(VB_START);
    localparam logic [CW-1:0] NMI_C      = CW'(NMI_LINE);
    localparam logic [CW-1:0] IRQ_MASK_C = CW'((1 << IRQ_SHIFT) - 1);
    localparam logic [CW-1:0] FLIP_X_C   = CW'(FLIP_XMAX);
    localparam logic [CW-1:0] FLIP_Y_C   = CW'(FLIP_YMAX);

    if (H_TOTAL > (1 << CW)) begin : gBadHTotal
        $error("video_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (V_TOTAL > (1 << CW)) begin : gBadVTotal
        $error("video_timing_gen: V_TOTAL does not fit in CW bits");
    end

    logic [CW-1:0] hcount_q, hcount_d;
    logic [CW-1:0] vcount_q, vcount_d;
    logic [CW-1:0] hcount_f_q, hcount_f_d;
    logic [CW-1:0] vcount_f_q, vcount_f_d;
    logic [CW-1:0] hMirrorSrc;
    logic [CW-1:0] vMirrorSrc;
    logic [7:0]    frame_q, frame_d;
    logic          hb_q, hb_d;
    logic          vb_q, vb_d;
    logic          nmi_q, nmi_d;
    logic          irq_q, irq_d;
    logic          lineEnd;
    logic          frameEnd;
    logic          irqLine;

    assign lineEnd  = ce_pix && (hcount_q == H_LAST_C);
    assign frameEnd = lineEnd && (vcount_q == V_LAST_C);
    assign irqLine  = (IRQ_SHIFT != 0) && ((vcount_q & IRQ_MASK_C) == IRQ_MASK_C);

    // Counter advance, blanking edges and interrupt strobes for the current pixel step.
    always_comb begin
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        frame_d  = frame_q;
        hb_d     = hb_q;
        vb_d     = vb_q;
        nmi_d    = nmi_q;
        irq_d    = irq_q;
        if (ce_pix) begin
            hcount_d = lineEnd ? '0 : hcount_q + ONE_C;
            if (hcount_q == HB_START_C) begin
                hb_d = 1'b1;
            end
            if (hcount_q == HB_END_C) begin
                hb_d = 1'b0;
            end
            nmi_d = (vcount_q == NMI_C) && (hcount_q == '0);
            if (lineEnd) begin
                vcount_d = frameEnd ? '0 : vcount_q + ONE_C;
                if (vcount_q == VB_START_C) begin
                    vb_d = 1'b1;
                end
                if (vcount_q == VB_END_C) begin
                    vb_d = 1'b0;
                end
            end
            if (frameEnd) begin
                frame_d = frame_q + 8'd1;
            end
        end
        if (irq_ack) begin
            irq_d = 1'b0;
        end
        if (ce_pix && irqLine && (hcount_q == '0)) begin
            irq_d = 1'b1;
        end
    end

    // Mirrored counters track the counters one clock late; reset mirrors zero.
    always_comb begin
        hMirrorSrc = reset ? '0 : hcount_q;
        vMirrorSrc = reset ? '0 : vcount_q;
        hcount_f_d = flip ? FLIP_X_C - hMirrorSrc : hMirrorSrc;
        vcount_f_d = flip ? FLIP_Y_C - vMirrorSrc : vMirrorSrc;
    end

    // Timing state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            hcount_q <= '0;
            vcount_q <= '0;
            frame_q  <= '0;
            hb_q     <= 1'b1;
            vb_q     <= 1'b1;
            nmi_q    <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            frame_q  <= frame_d;
            hb_q     <= hb_d;
            vb_q     <= vb_d;
            nmi_q    <= nmi_d;
            irq_q    <= irq_d;
        end
    end

    // Flip-adjusted counters update every clock, independent of the pixel enable.
    always_ff @(posedge clk) begin
        hcount_f_q <= hcount_f_d;
        vcount_f_q <= vcount_f_d;
    end

    video_sync_window #(
        .CW    (CW),
        .TOTAL (H_TOTAL),
        .START (HS_START),
        .STOP  (HS_END),
        .AW    (4)
    ) uHSync (
        .clk     (clk),
        .reset   (reset),
        .step_i  (ce_pix),
        .latch_i (frameEnd),
        .cnt_i   (hcount_q),
        .adj_i   ($signed(h_adj)),
        .sync_o  (hs)
    );

    video_sync_window #(
        .CW    (CW),
        .TOTAL (V_TOTAL),
        .START (VS_START),
        .STOP  (VS_END),
        .AW    (3)
    ) uVSync (
        .clk     (clk),
        .reset   (reset),
        .step_i  (lineEnd),
        .latch_i (frameEnd),
        .cnt_i   (vcount_q),
        .adj_i   ($signed(v_adj)),
        .sync_o  (vs)
    );

    assign hcount   = hcount_q;
    assign vcount   = vcount_q;
    assign hcount_f = hcount_f_q;
    assign vcount_f = vcount_f_q;
    assign frame    = frame_q;
    assign hb       = hb_q;
    assign vb       = vb_q;
    assign nmi      = nmi_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen using a reduced geometry (16 x 12,
// 192 clocks per frame) so that a full 256-frame wrap stays short.
module tb_video_timing_gen;

    logic       clk;
    logic       reset;
    logic       ce_pix;
    logic       flip;
    logic [3:0] h_adj;
    logic [2:0] v_adj;
    logic       irq_ack;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic [8:0] hcount_f;
    logic [8:0] vcount_f;
    logic       hb;
    logic       vb;
    logic       hs;
    logic       vs;
    logic       nmi;
    logic       irq;
    logic [7:0] frame;

    int total = 0;
    int bad = 0;
    int clkCnt = 0;
    int divCnt = 0;
    int nmiCount = 0;

    video_timing_gen #(
        .CW        (9),
        .H_TOTAL   (16),
        .HB_END    (1),
        .HB_START  (10),
        .HS_START  (12),
        .HS_END    (14),
        .V_TOTAL   (12),
        .VB_END    (0),
        .VB_START  (8),
        .VS_START  (9),
        .VS_END    (11),
        .NMI_LINE  (7),
        .IRQ_SHIFT (2),
        .FLIP_XMAX (255),
        .FLIP_YMAX (255)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ce_pix   (ce_pix),
        .flip     (flip),
        .h_adj    (h_adj),
        .v_adj    (v_adj),
        .irq_ack  (irq_ack),
        .hcount   (hcount),
        .vcount   (vcount),
        .hcount_f (hcount_f),
        .vcount_f (vcount_f),
        .hb       (hb),
        .vb       (vb),
        .hs       (hs),
        .vs       (vs),
        .nmi      (nmi),
        .irq      (irq),
        .frame    (frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the given number of clocks with the inputs as currently driven.
    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            clkCnt++;
        end
    endtask

    task automatic runTo(input int target);
        applyStimulus(target - clkCnt);
    endtask

    // Pixel enable on one clock in four, counted from divCnt = 0.
    task automatic runDivTo(input int target);
        while (divCnt < target) begin
            ce_pix = (divCnt % 4 == 0);
            applyStimulus(1);
            divCnt++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d (clk=%0d)", tag, observed, expected, clkCnt);
        end
    endtask

    initial begin
        reset   = 1'b1;
        ce_pix  = 1'b1;
        flip    = 1'b1;
        h_adj   = 4'd0;
        v_adj   = 3'd0;
        irq_ack = 1'b0;

        $display("[TB] reset with flip=1");
        applyStimulus(2);
        checkOutput("rst_hcount", 32'(hcount), 0);
        checkOutput("rst_vcount", 32'(vcount), 0);
        checkOutput("rst_frame", 32'(frame), 0);
        checkOutput("rst_hb", 32'(hb), 1);
        checkOutput("rst_vb", 32'(vb), 1);
        checkOutput("rst_hs", 32'(hs), 1);
        checkOutput("rst_vs", 32'(vs), 1);
        checkOutput("rst_nmi", 32'(nmi), 0);
        checkOutput("rst_irq", 32'(irq), 0);
        checkOutput("rst_hcount_f", 32'(hcount_f), 255);
        checkOutput("rst_vcount_f", 32'(vcount_f), 255);

        $display("[TB] free-running line and frame, ce_pix=1");
        flip   = 1'b0;
        reset  = 1'b0;
        clkCnt = 0;
        runTo(1);
        checkOutput("hcount_t1", 32'(hcount), 1);
        checkOutput("hb_before_fall", 32'(hb), 1);
        checkOutput("hcount_f_t1", 32'(hcount_f), 0);
        runTo(2);
        checkOutput("hb_fall", 32'(hb), 0);
        runTo(5);
        checkOutput("hcount_f_lag", 32'(hcount_f), 4);
        runTo(10);
        checkOutput("hb_low_h10", 32'(hb), 0);
        runTo(11);
        checkOutput("hb_rise", 32'(hb), 1);
        runTo(12);
        checkOutput("hs_high_h12", 32'(hs), 1);
        runTo(13);
        checkOutput("hs_low_h13", 32'(hs), 0);
        runTo(14);
        checkOutput("hs_low_h14", 32'(hs), 0);
        runTo(15);
        checkOutput("hs_rise", 32'(hs), 1);
        runTo(16);
        checkOutput("line_wrap_h", 32'(hcount), 0);
        checkOutput("line_wrap_v", 32'(vcount), 1);
        checkOutput("vb_fall", 32'(vb), 0);

        $display("[TB] irq set and acknowledge");
        runTo(48);
        checkOutput("irq_before_l3", 32'(irq), 0);
        runTo(49);
        checkOutput("irq_set_l3", 32'(irq), 1);
        runTo(58);
        irq_ack = 1'b1;
        runTo(59);
        checkOutput("irq_acked", 32'(irq), 0);
        irq_ack = 1'b0;
        runTo(60);
        irq_ack = 1'b1;
        runTo(61);
        checkOutput("ack_while_idle", 32'(irq), 0);
        irq_ack = 1'b0;
        runTo(112);
        checkOutput("irq_idle_l7", 32'(irq), 0);
        checkOutput("nmi_before", 32'(nmi), 0);
        irq_ack = 1'b1;
        runTo(113);
        checkOutput("irq_set_beats_ack", 32'(irq), 1);
        checkOutput("nmi_pulse", 32'(nmi), 1);
        checkOutput("nmi_line", 32'(vcount), 7);
        runTo(114);
        checkOutput("irq_ack_after", 32'(irq), 0);
        checkOutput("nmi_one_cycle", 32'(nmi), 0);
        irq_ack = 1'b0;

        $display("[TB] vertical blanking and sync");
        runTo(143);
        checkOutput("vb_low_l8", 32'(vb), 0);
        runTo(144);
        checkOutput("vb_rise", 32'(vb), 1);
        runTo(159);
        checkOutput("vs_high_l9", 32'(vs), 1);
        runTo(160);
        checkOutput("vs_fall", 32'(vs), 0);
        runTo(191);
        checkOutput("frame_before_wrap", 32'(frame), 0);
        checkOutput("vs_low_l11", 32'(vs), 0);
        runTo(192);
        checkOutput("frame_wrap_cnt", 32'(frame), 1);
        checkOutput("frame_wrap_v", 32'(vcount), 0);
        checkOutput("frame_wrap_h", 32'(hcount), 0);
        checkOutput("vs_rise", 32'(vs), 1);
        checkOutput("vb_high_l0", 32'(vb), 1);

        $display("[TB] sync shift written mid-frame");
        runTo(200);
        h_adj = 4'b1101;
        v_adj = 3'b011;
        runTo(208);
        checkOutput("vb_fall_f1", 32'(vb), 0);
        runTo(218);
        checkOutput("hs_old_h10", 32'(hs), 1);
        runTo(221);
        checkOutput("hs_old_h13", 32'(hs), 0);
        runTo(352);
        checkOutput("vs_old_l10", 32'(vs), 0);
        runTo(393);
        checkOutput("hs_new_h9", 32'(hs), 1);
        runTo(394);
        checkOutput("hs_new_h10", 32'(hs), 0);
        runTo(396);
        checkOutput("hs_new_h12", 32'(hs), 1);
        runTo(397);
        checkOutput("hs_new_h13", 32'(hs), 1);
        runTo(399);
        checkOutput("vs_new_l0", 32'(vs), 1);
        runTo(400);
        checkOutput("vs_new_l1", 32'(vs), 0);
        runTo(431);
        checkOutput("vs_new_l2", 32'(vs), 0);
        runTo(432);
        checkOutput("vs_new_l3", 32'(vs), 1);
        runTo(544);
        checkOutput("vs_new_l10", 32'(vs), 1);

        $display("[TB] reset mid-frame with irq pending");
        runTo(550);
        checkOutput("pre_rst_h", 32'(hcount), 6);
        checkOutput("pre_rst_v", 32'(vcount), 10);
        checkOutput("pre_rst_irq", 32'(irq), 1);
        reset  = 1'b1;
        ce_pix = 1'b0;
        applyStimulus(1);
        checkOutput("mid_rst_h", 32'(hcount), 0);
        checkOutput("mid_rst_v", 32'(vcount), 0);
        checkOutput("mid_rst_irq", 32'(irq), 0);
        checkOutput("mid_rst_frame", 32'(frame), 0);
        checkOutput("mid_rst_syncblank", 32'({hb, vb, hs, vs}), 15);
        checkOutput("mid_rst_hcount_f", 32'(hcount_f), 0);

        $display("[TB] ce_pix divide-by-4 with flip");
        reset  = 1'b0;
        flip   = 1'b1;
        divCnt = 0;
        runDivTo(1);
        checkOutput("div_h_c1", 32'(hcount), 1);
        checkOutput("div_hf_c1", 32'(hcount_f), 255);
        runDivTo(2);
        checkOutput("div_hf_c2", 32'(hcount_f), 254);
        runDivTo(4);
        checkOutput("div_h_hold", 32'(hcount), 1);
        checkOutput("div_hb_c4", 32'(hb), 1);
        runDivTo(5);
        checkOutput("div_h_c5", 32'(hcount), 2);
        checkOutput("div_hb_c5", 32'(hb), 0);
        runDivTo(40);
        checkOutput("div_h_c40", 32'(hcount), 10);
        checkOutput("div_hs_adj_cleared", 32'(hs), 1);
        runDivTo(52);
        checkOutput("div_h_c52", 32'(hcount), 13);
        checkOutput("div_hs_low", 32'(hs), 0);
        runDivTo(60);
        checkOutput("div_h_c60", 32'(hcount), 15);
        checkOutput("div_v_c60", 32'(vcount), 0);
        checkOutput("div_hs_c60", 32'(hs), 1);
        runDivTo(61);
        checkOutput("div_h_c61", 32'(hcount), 0);
        checkOutput("div_v_c61", 32'(vcount), 1);
        checkOutput("div_hf_c61", 32'(hcount_f), 240);
        checkOutput("div_vf_c61", 32'(vcount_f), 255);
        flip = 1'b0;
        runDivTo(62);
        checkOutput("unflip_hf", 32'(hcount_f), 0);
        checkOutput("unflip_vf", 32'(vcount_f), 1);

        $display("[TB] 256-frame run for frame counter wrap");
        reset   = 1'b1;
        ce_pix  = 1'b1;
        irq_ack = 1'b0;
        applyStimulus(1);
        reset    = 1'b0;
        clkCnt   = 0;
        nmiCount = 0;
        while (clkCnt < 49151) begin
            applyStimulus(1);
            if (nmi) begin
                nmiCount++;
            end
        end
        checkOutput("frame_255", 32'(frame), 255);
        applyStimulus(1);
        checkOutput("frame_wrap_0", 32'(frame), 0);
        checkOutput("frame_wrap_pos", 32'({vcount, hcount}), 0);
        checkOutput("nmi_per_frame", 32'(nmiCount), 256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
